// File: rtl/pixel_prefetch_fifo.sv
// Sequential image-memory prefetcher feeding a show-ahead byte FIFO for VGA scan-out.
// frame_start flushes the FIFO and restarts fetching at address 0.
module pixel_prefetch_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned FRAME_PIXELS = 307200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   pop,
  output logic [7:0]             pixel,
  output logic                   pixel_valid,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level,
  output logic                   mem_rd,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [7:0]             mem_data
);

  localparam int unsigned        PtrW     = $clog2(DEPTH);
  localparam logic [PtrW+1:0]    DepthW   = (PtrW + 2)'(DEPTH);
  localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              underrun_q, underrun_d;
  logic              wr_en, rd_en;
  logic [PtrW+1:0]   credit;

  // Occupancy plus the read already on its way back; a same-cycle pop earns no credit.
  always_comb begin
    credit = {1'b0, count_q} + {{(PtrW + 1){1'b0}}, inflight_q};
    mem_rd = (state_q == StRun) && (credit < DepthW);
  end

  always_comb begin
    wr_en = inflight_q & ~frame_start;
    rd_en = pop & (count_q != '0) & ~frame_start;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = state_q;
      StRun:   if (mem_rd && (addr_q == LastAddr)) state_d = StDone;
      StDone:  state_d = state_q;
      default: state_d = StIdle;
    endcase
    if (frame_start) state_d = StRun;
  end

  always_comb begin
    wptr_d     = wr_en ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d     = rd_en ? rptr_q + PtrW'(1) : rptr_q;
    count_d    = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
    addr_d     = mem_rd ? addr_q + ADDR_W'(1) : addr_q;
    inflight_d = mem_rd;
    underrun_d = underrun_q | (pop & (count_q == '0));
    // Flush wins over everything; the return due next cycle is dropped via inflight.
    if (frame_start) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      addr_d     = '0;
      inflight_d = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= mem_data;
  end

  always_comb begin
    pixel_valid = (count_q != '0);
    pixel       = pixel_valid ? mem_q[rptr_q] : 8'h00;
    level       = count_q;
    mem_addr    = addr_q;
    underrun    = underrun_q;
  end

endmodule

// File: tb/tb_pixel_prefetch_fifo.sv
// Randomized bench for pixel_prefetch_fifo against a queue-based model of the prefetcher.
module tb_pixel_prefetch_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned FP     = 1100;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   frame_start = 1'b0;
  logic                   pop = 1'b0;
  logic [7:0]             pixel;
  logic                   pixel_valid;
  logic                   underrun;
  logic [$clog2(DEPTH):0] level;
  logic                   mem_rd;
  logic [ADDR_W-1:0]      mem_addr;
  logic [7:0]             mem_data = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  // Model: FIFO contents, outstanding read, fetch pointer, whether fetching is active.
  logic [7:0] m_fifo[$];
  bit         m_run;
  bit         m_inflight;
  int         m_inflight_addr;
  int         m_addr;
  bit         m_underrun;
  int         last_issued;

  pixel_prefetch_fifo #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .FRAME_PIXELS(FP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .pop        (pop),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .underrun   (underrun),
    .level      (level),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  always #20 clk = ~clk;

  // Image memory: one-cycle latency, byte = low address bits, junk when not read.
  always @(posedge clk) mem_data <= mem_rd ? mem_addr[7:0] : 8'($urandom);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_rd();
    return m_run && ((m_fifo.size() + int'(m_inflight)) < int'(DEPTH));
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_run      = 1'b0;
    m_inflight = 1'b0;
    m_addr     = 0;
    m_underrun = 1'b0;
  endtask

  // One cycle: drive inputs, compare all outputs to the model, then advance the model.
  task automatic step(input bit fs, input bit pp);
    bit rd;
    @(negedge clk);
    frame_start = fs;
    pop         = pp;
    rd = model_rd();
    check_eq("mem_rd", 32'(mem_rd), 32'(rd));
    if (rd) check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
    check_eq("level", 32'(level), 32'(m_fifo.size()));
    check_eq("pixel_valid", 32'(pixel_valid), 32'(m_fifo.size() != 0));
    check_eq("pixel", 32'(pixel), 32'((m_fifo.size() != 0) ? m_fifo[0] : 8'h00));
    check_eq("underrun", 32'(underrun), 32'(m_underrun));
    if (level > DEPTH) check_eq("overflow", 32'(level), 32'(DEPTH));
    if (mem_rd) last_issued = int'(mem_addr);
    if (fs) begin
      model_reset();
      m_run = 1'b1;
    end else begin
      if (pp) begin
        if (m_fifo.size() != 0) void'(m_fifo.pop_front());
        else m_underrun = 1'b1;
      end
      if (m_inflight) m_fifo.push_back(m_inflight_addr[7:0]);
      m_inflight      = rd;
      m_inflight_addr = m_addr;
      if (rd) begin
        if (m_addr == int'(FP) - 1) m_run = 1'b0;
        m_addr++;
      end
    end
  endtask

  initial begin
    int k;
    model_reset();
    last_issued = -1;

    repeat (2) @(negedge clk);
    check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_pixel", 32'(pixel), 32'd0);
    check_eq("rst_valid", 32'(pixel_valid), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0);

    // Fill with no pops.
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    check_eq("fill_level", 32'(level), 32'(DEPTH));
    check_eq("fill_rd", 32'(mem_rd), 32'd0);
    check_eq("fill_last_addr", 32'(last_issued), 32'd15);
    check_eq("fill_pixel", 32'(pixel), 32'd0);
    check_eq("fill_valid", 32'(pixel_valid), 32'd1);

    // Sustained pop every cycle.
    repeat (1000) step(1'b0, 1'b1);
    check_eq("stream_underrun", 32'(underrun), 32'd0);
    check_eq("stream_level", 32'(level), 32'd14);
    check_eq("stream_pixel", 32'(pixel), 32'(999 % 256));

    // Random pops with occasional frame restarts.
    for (int i = 0; i < 600; i++) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);

    // Pop on empty right after restart, then restart mid-frame with reads in flight.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("empty_pop_underrun", 32'(underrun), 32'd1);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("mid_level", 32'(level), 32'd0);
    check_eq("mid_underrun", 32'(underrun), 32'd0);
    check_eq("mid_rd", 32'(mem_rd), 32'd1);
    check_eq("mid_addr", 32'(mem_addr), 32'd0);
    repeat (2) step(1'b0, 1'b0);
    check_eq("mid_pixel", 32'(pixel), 32'd0);
    check_eq("mid_valid", 32'(pixel_valid), 32'd1);

    // frame_start with a simultaneous pop on a non-empty FIFO.
    repeat (6) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_eq("fs_pop_level", 32'(level), 32'd0);
    check_eq("fs_pop_underrun", 32'(underrun), 32'd0);

    // Run a whole frame to DONE and drain.
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    k = 0;
    while ((m_run || m_inflight || m_fifo.size() != 0) && k < 6000) begin
      step(1'b0, $urandom_range(0, 4) != 0);
      k++;
    end
    if (k >= 6000) check_eq("done_timeout", 32'd0, 32'd1);
    check_eq("done_last_addr", 32'(last_issued), 32'(FP - 1));
    check_eq("done_rd", 32'(mem_rd), 32'd0);
    check_eq("done_underrun", 32'(underrun), 32'd0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("done_extra_pop", 32'(underrun), 32'd1);
    repeat (5) step(1'b0, 1'b0);

    // Asynchronous reset between edges during RUN.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    #5 reset = 1'b1;
    #1;
    check_eq("arst_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("arst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("arst_level", 32'(level), 32'd0);
    check_eq("arst_pixel", 32'(pixel), 32'd0);
    check_eq("arst_valid", 32'(pixel_valid), 32'd0);
    check_eq("arst_underrun", 32'(underrun), 32'd0);
    #5 reset = 1'b0;
    model_reset();
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
